// File: rtl/core_dmem_bridge.sv
// MEM-stage data port to valid/ready data-memory bus bridge: builds strobes and lane-shifted
// store data, aligns and extends load data, stalls the pipe, flags misalignment and timeouts.
module core_dmem_bridge #(
   parameter int ADDR_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            read_type,
   input  logic [1:0]            write_type,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [63:0]           mem_wdata,
   output logic [63:0]           mem_rdata,
   output logic                  mem_stall,
   output logic                  access_err,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_req_we,
   output logic [ADDR_WIDTH-1:0] bus_req_addr,
   output logic [63:0]           bus_req_wdata,
   output logic [7:0]            bus_req_wstrb,
   input  logic                  bus_rsp_valid,
   input  logic [63:0]           bus_rsp_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [63:0]           r_wdata;
   logic [7:0]            r_wstrb;
   logic [2:0]            r_rtype;
   logic [2:0]            r_off;
   logic [7:0]            r_cnt;
   logic [63:0]           r_rdata;
   logic                  r_err;

   logic                  w_acc;
   logic [1:0]            w_sz;
   logic [2:0]            w_off;
   logic                  w_mis;
   logic [7:0]            w_mask;
   logic [63:0]           w_sh;
   logic [63:0]           w_ext;
   logic                  w_tmo;

   assign w_acc = mem_read | mem_write;
   assign w_sz  = mem_write ? write_type : read_type[1:0];
   assign w_off = mem_addr[2:0];

   always_comb begin
      w_mis  = 1'b0;
      w_mask = 8'h01;
      case (w_sz)
         2'd0: begin w_mis = 1'b0;         w_mask = 8'h01; end
         2'd1: begin w_mis = w_off[0];     w_mask = 8'h03; end
         2'd2: begin w_mis = |w_off[1:0];  w_mask = 8'h0F; end
         default: begin w_mis = |w_off;    w_mask = 8'hFF; end
      endcase
   end

   // Load data is extracted from the lane captured at request time, not the live address.
   assign w_sh = bus_rsp_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ext = w_sh;
      case (r_rtype)
         3'b000: w_ext = {{56{w_sh[7]}},  w_sh[7:0]};
         3'b001: w_ext = {{48{w_sh[15]}}, w_sh[15:0]};
         3'b010: w_ext = {{32{w_sh[31]}}, w_sh[31:0]};
         3'b100: w_ext = {56'd0, w_sh[7:0]};
         3'b101: w_ext = {48'd0, w_sh[15:0]};
         3'b110: w_ext = {32'd0, w_sh[31:0]};
         default: w_ext = w_sh;
      endcase
   end

   // Last budgeted cycle: valid is withdrawn so a ready here cannot start a transfer we abort.
   assign w_tmo = ((r_state == S_REQ) || (r_state == S_WAIT)) && (r_cnt == TMO_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_acc) w_next = w_mis ? S_DONE : S_REQ;
         S_REQ:   if (w_tmo) w_next = S_DONE;
                  else if (bus_req_ready) w_next = r_we ? S_DONE : S_WAIT;
         S_WAIT:  if (bus_rsp_valid || w_tmo) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rtype <= '0;
         r_off   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: if (w_acc) begin
               if (w_mis) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_addr  <= {mem_addr[ADDR_WIDTH-1:3], 3'b000};
                  r_we    <= mem_write;
                  r_wdata <= mem_wdata << {w_off, 3'b000};
                  r_wstrb <= mem_write ? (w_mask << w_off) : 8'h00;
                  r_rtype <= read_type;
                  r_off   <= w_off;
                  r_cnt   <= '0;
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (bus_rsp_valid) r_rdata <= w_ext;
               else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (r_state)
         S_IDLE:  mem_stall = w_acc;
         S_DONE:  mem_stall = 1'b0;
         default: mem_stall = 1'b1;
      endcase
      mem_stall = mem_stall & rst_n;
   end

   assign bus_req_valid = (r_state == S_REQ) && !w_tmo;
   assign bus_req_we    = r_we;
   assign bus_req_addr  = r_addr;
   assign bus_req_wdata = r_wdata;
   assign bus_req_wstrb = r_wstrb;
   assign mem_rdata     = r_rdata;
   assign access_err    = r_err;

endmodule

// File: tb/tb_core_dmem_bridge.sv
// Randomized bench for core_dmem_bridge: a reactive bus model drives ready/response and a
// transaction-level model predicts stall length, error, bus fields and load results.
module tb_core_dmem_bridge;

   localparam int T     = 4;
   localparam int LIMIT = T + 6;

   logic        clk, rst_n;
   logic        mem_read, mem_write;
   logic [2:0]  read_type;
   logic [1:0]  write_type;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_stall, access_err;
   logic        bus_req_valid, bus_req_ready, bus_req_we;
   logic [63:0] bus_req_addr, bus_req_wdata;
   logic [7:0]  bus_req_wstrb;
   logic        bus_rsp_valid;
   logic [63:0] bus_rsp_rdata;

   int          n_pass = 0;
   int          n_chk  = 0;
   logic [63:0] model_rdata = 64'd0;

   core_dmem_bridge #(.ADDR_WIDTH(64), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write),
      .read_type(read_type), .write_type(write_type),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .access_err(access_err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
      .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [63:0] ext(input logic [63:0] d, input logic [2:0] t, input logic [2:0] off);
      int nb;
      logic [63:0] raw, mask;
      nb   = 1 << t[1:0];
      raw  = d >> (8 * off);
      mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
      raw  = raw & mask;
      if (!t[2] && nb < 8 && raw[8*nb-1]) raw = raw | ~mask;
      return raw;
   endfunction

   // d: cycles of REQ before ready rises; l: response delay after the handshake
   task automatic run_access(input bit st, input bit both, input logic [2:0] typ,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] rd, input int d, input int l);
      int nb, k, acc_k, exp_done;
      bit mis, ok, acc, seen;
      logic [2:0]  off;
      logic [63:0] exp_wd;
      logic [7:0]  exp_strb;
      off  = addr[2:0];
      nb   = 1 << typ[1:0];
      mis  = (int'(off) % nb) != 0;
      if (st) ok = !mis && (d + 1 <= T - 1);
      else    ok = !mis && (d + 1 <= T - 1) && (d + 1 + l <= T);
      exp_done = mis ? 1 : (ok ? (st ? d + 2 : d + l + 2) : T + 1);
      exp_wd   = st ? (wd << (8 * off)) : 64'd0;
      exp_strb = st ? 8'(((1 << nb) - 1) << off) : 8'h00;
      if (mis || !ok) model_rdata = 64'd0;
      else if (!st)   model_rdata = ext(rd, typ, off);

      mem_read = !st || both; mem_write = st; read_type = typ; write_type = typ[1:0];
      mem_addr = addr; mem_wdata = wd;
      acc = 0; seen = 0; acc_k = 0; k = 0;
      while (k < LIMIT) begin
         bus_req_ready = (k >= d + 1);
         bus_rsp_valid = acc && (k == acc_k + l);
         bus_rsp_rdata = bus_rsp_valid ? rd : {$urandom, $urandom};
         #1;
         if (!mem_stall) break;
         if (bus_req_valid) begin
            seen = 1;
            chk("req_addr", bus_req_addr, addr & ~64'h7);
            chk("req_we", {63'd0, bus_req_we}, {63'd0, st});
            chk("req_wstrb", {56'd0, bus_req_wstrb}, {56'd0, exp_strb});
            if (st) chk("req_wdata", bus_req_wdata, exp_wd);
            if (bus_req_ready) begin acc = 1; acc_k = k; end
         end
         @(negedge clk);
         k++;
      end
      chk("done_cycle", 64'(k), 64'(exp_done));
      chk("done_err", {63'd0, access_err}, {63'd0, (mis || !ok)});
      chk("done_rdata", mem_rdata, model_rdata);
      chk("valid_seen", {63'd0, seen}, {63'd0, !mis});
      chk("done_valid", {63'd0, bus_req_valid}, 64'd0);

      // stray responses in DONE and IDLE must be ignored
      mem_read = 0; mem_write = 0; bus_req_ready = 0;
      bus_rsp_valid = 1; bus_rsp_rdata = {$urandom, $urandom};
      @(negedge clk);
      @(negedge clk);
      bus_rsp_valid = 0;
      #1;
      chk("idle_err", {63'd0, access_err}, 64'd0);
      chk("idle_stall", {63'd0, mem_stall}, 64'd0);
      chk("hold_rdata", mem_rdata, model_rdata);
   endtask

   initial begin
      rst_n = 0; mem_read = 0; mem_write = 0; read_type = 0; write_type = 0;
      mem_addr = 0; mem_wdata = 0; bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
      #1;
      chk("rst_stall", {63'd0, mem_stall}, 64'd0);
      chk("rst_err", {63'd0, access_err}, 64'd0);
      chk("rst_valid", {63'd0, bus_req_valid}, 64'd0);
      chk("rst_addr", bus_req_addr, 64'd0);
      chk("rst_wstrb", {56'd0, bus_req_wstrb}, 64'd0);
      chk("rst_rdata", mem_rdata, 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      run_access(1, 0, 3'd3, 64'h1000, 64'h1122334455667788, 64'd0, 0, 1);   // SD
      run_access(1, 0, 3'd0, 64'h1003, 64'hAB, 64'd0, 0, 1);                 // SB
      run_access(0, 0, 3'd0, 64'h2005, 64'd0, 64'h0000800000000000, 0, 1);   // LB
      run_access(0, 0, 3'd4, 64'h2005, 64'd0, 64'h0000800000000000, 0, 1);   // LBU
      run_access(0, 0, 3'd2, 64'h3006, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);// LW misaligned
      run_access(0, 0, 3'd6, 64'h3004, 64'd0, 64'h8765432112345678, 1, 1);   // LWU upper word
      run_access(0, 0, 3'd3, 64'h6000, 64'd0, 64'h1, 0, 99);                 // timeout
      run_access(1, 1, 3'd2, 64'h5004, 64'hDEADBEEF, 64'd0, 2, 1);           // SW, ready late
      run_access(0, 0, 3'd7, 64'h7000, 64'd0, 64'hF0F0F0F0F0F0F0F0, 0, 2);   // illegal -> LD

      for (int i = 0; i < 200; i++) begin
         bit st, both;
         logic [2:0]  typ;
         logic [63:0] a;
         int nb;
         st   = ($urandom % 2) != 0;
         both = st && (($urandom % 4) == 0);
         typ  = st ? 3'($urandom % 4) : 3'($urandom % 8);
         nb   = 1 << typ[1:0];
         a    = {$urandom, $urandom};
         if (($urandom % 4) != 0) a[2:0] = a[2:0] & 3'(~(nb - 1));
         run_access(st, both, typ, a, {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      end

      // reset in REQ drops valid and stall at once
      mem_read = 1; mem_write = 0; read_type = 3'd3; mem_addr = 64'h4000;
      bus_req_ready = 0; bus_rsp_valid = 0;
      @(negedge clk);
      #1;
      chk("pre_rst_valid", {63'd0, bus_req_valid}, 64'd1);
      rst_n = 0; model_rdata = 64'd0;
      #1;
      chk("rst_req_valid", {63'd0, bus_req_valid}, 64'd0);
      chk("rst_req_stall", {63'd0, mem_stall}, 64'd0);
      chk("rst_req_rdata", mem_rdata, model_rdata);
      @(negedge clk);
      rst_n = 1; bus_req_ready = 1;
      @(negedge clk);
      #1;
      chk("re_req_valid", {63'd0, bus_req_valid}, 64'd1);
      @(negedge clk);
      bus_req_ready = 0;
      #1;
      chk("wait_stall", {63'd0, mem_stall}, 64'd1);
      rst_n = 0;
      #1;
      chk("rst_wait_stall", {63'd0, mem_stall}, 64'd0);
      chk("rst_wait_valid", {63'd0, bus_req_valid}, 64'd0);
      mem_read = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_dmem_bridge.md
Name: core_dmem_bridge

Overview:
- Sits between the core's MEM-stage data port and the data-memory bus. Consumes the memory-access signals (mem_read, mem_write, read_type, write_type, mem_addr, mem_wdata).
- Converts each access into a valid/ready request plus a response handshake. Generates byte strobes, aligns and sign/zero-extends load data, and stalls the pipeline until the access completes.
- Also detects misaligned accesses and bus timeouts.

Parameters:
- ADDR_WIDTH, 64, byte-address width (matches OPERAND_WIDTH).
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ plus WAIT_RSP before an access is aborted; range 1..255.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- mem_read  input  1  load request from MEM stage
- mem_write  input  1  store request from MEM stage
- read_type  input  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is illegal and treated as LD
- write_type  input  2  00 SB, 01 SH, 10 SW, 11 SD
- mem_addr  input  ADDR_WIDTH  byte address
- mem_wdata  input  64  store data, LSB-justified
- mem_rdata  output  64  extended load result
- mem_stall  output  1  hold pipeline
- access_err  output  1  one-cycle pulse on a misaligned access or a timeout
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  request accepted
- bus_req_we  output  1  1 = write
- bus_req_addr  output  ADDR_WIDTH  mem_addr with bits [2:0] forced to 0
- bus_req_wdata  output  64  store data shifted into its byte lanes
- bus_req_wstrb  output  8  byte-lane enables; 0 for reads
- bus_rsp_valid  input  1  response valid; single cycle, no backpressure
- bus_rsp_rdata  input  64  aligned doubleword read data

Behaviour:
- Reset values: state IDLE, all outputs 0, timeout counter 0, mem_rdata register 0.
- Access size: 1, 2, 4 or 8 bytes, from type[1:0].
- Lane offset: off = mem_addr[2:0].
  - Store: bus_req_wdata = mem_wdata << (8*off); wstrb = size mask << off.
  - Load: raw = bus_rsp_rdata >> (8*off), truncated to size, then sign-extended (read_type[2] = 0) or zero-extended (read_type[2] = 1).
- Misaligned: off not a multiple of size.
- mem_read and mem_write both high: treat the access as a store.
- States:
  - IDLE
    - mem_stall = mem_read | mem_write (combinational).
    - Aligned access: capture addr, we, wdata, wstrb and read_type into registers; go to REQ.
    - Misaligned access: pulse access_err, mem_rdata = 0, go to DONE; no bus request is issued.
  - REQ
    - bus_req_valid = 1; request fields stay stable until bus_req_ready.
    - On bus_req_ready: store goes to DONE; load goes to WAIT_RSP.
  - WAIT_RSP
    - On bus_rsp_valid, register the extended data into mem_rdata and go to DONE.
    - A bus_rsp_valid in the same cycle as the ready handshake is not possible; the bus guarantees at least one cycle of latency.
  - DONE
    - mem_stall = 0 for exactly one cycle; mem_rdata is valid; the pipeline advances.
    - Next state is IDLE; inputs are not sampled in DONE.
- mem_stall is 1 in REQ and WAIT_RSP. Best-case latency: store 2 cycles stalled, load 3 cycles stalled, then the DONE cycle.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle spent in REQ or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES: drop bus_req_valid, pulse access_err, set mem_rdata = 0, go to DONE.
  - A late bus_rsp_valid arriving after a timeout is ignored in every state other than WAIT_RSP.
- mem_rdata holds its value until the next load completes; stores do not modify it.
- Reset asserted mid-access returns the block to IDLE immediately and drops bus_req_valid asynchronously.

Test Plan:
- SD with addr=0x1000, wdata=0x1122334455667788, bus_req_ready high → REQ on cycle 1 with addr 0x1000, wstrb 0xFF; DONE on cycle 2, stall low.
- SB with addr=0x1003, wdata=0xAB → wdata=0x00000000AB000000, wstrb=0x08, bus_req_addr=0x1000.
- LB with addr=0x2005, rsp_rdata=0x0000_8000_0000_0000, response one cycle after ready → mem_rdata=0xFFFFFFFFFFFFFF80 in DONE. Repeat as LBU → 0x80.
- LW with addr=0x3006 (misaligned) → access_err pulses, no bus_req_valid, mem_rdata=0, stall released after 1 cycle.
- Load with bus_req_ready held high and rsp never sent, TIMEOUT_CYCLES=4 → access_err after 4 cycles in REQ/WAIT_RSP, DONE, then IDLE; a rsp_valid arriving afterwards is ignored.
- bus_req_ready low for 3 cycles with addr and wdata checked stable each cycle, then rst_n pulsed low while in WAIT_RSP → bus_req_valid and mem_stall go to 0 immediately.
